stream_block_sum: RTL and testbench
===================================

Name: stream_block_sum

Overview:
- Downstream consumer of the Top datapath stream.
- Accepts unsigned samples over a valid/ready handshake and sums each block of N samples, or a shorter block terminated by i_last.
- Emits one {sum, count, last} record per block through a 2-entry output FIFO.
- Gives the Nicotb bench a checkable reduced stream without per-sample scoreboarding.

Parameters:
DW, 8, input sample width (unsigned)
N, 4, samples per full block (N >= 2)
CW, $clog2(N+1), width of block-count field (derived, not overridable)
OW, DW+$clog2(N), output sum width (derived; a full block of max samples cannot overflow)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, synchronous, active-high
i_valid  input  1  sample present
i_ready  output  1  block can accept a sample this cycle
i_data  input  DW  sample value
i_last  input  1  marks final sample of a short block (qualified by i_valid)
o_valid  output  1  head record of output FIFO is valid
o_ready  input  1  downstream accepts head record
o_sum  output  OW  block sum, zero-extended accumulation
o_count  output  CW  number of samples in block, 1..N
o_last  output  1  1 if block closed by i_last, 0 if closed by reaching N

Behaviour:
- Reset (rst=1 at a clock edge): accumulator=0, sample counter=0, FIFO empty.
  - o_valid=0, o_sum=0, o_count=0, o_last=0, i_ready=0 during reset cycle; i_ready=1 the first cycle after rst deasserts.
  - Reset mid-block or with FIFO occupied discards all state; no partial record is ever emitted.
- Input accept: acc_fire = i_valid & i_ready. On acc_fire: acc += i_data, cnt += 1.
- Block close: on acc_fire when (cnt+1 == N) or i_last.
  - Push {acc+i_data, cnt+1, i_last & (cnt+1 != N)} into FIFO.
  - acc and cnt return to 0 in the same edge.
  - i_last on the N-th sample closes a normal full block with o_last=0.
- i_ready is registered: i_ready = !rst_q & (fifo_occupancy < 2).
  - FIFO free space is required only on closing samples, but i_ready gating is uniform on every sample.
  - i_ready has no combinational path from o_ready or i_valid.
  - Deassertion is conservative: when occupancy is 2, i_ready=0 even if o_ready=1 that cycle; it rises the cycle after the pop.
- Output FIFO: 2 entries, in-order.
  - o_valid = occupancy != 0; o_sum/o_count/o_last show the head entry, all 0 when empty.
  - Pop on o_valid & o_ready. Push and pop in the same cycle leave occupancy unchanged.
  - A push into an empty FIFO appears on o_valid the next cycle: latency from closing sample to o_valid is 1 cycle.
  - o_sum/o_count/o_last are held stable while o_valid & !o_ready.
- Handshake rules:
  - i_data/i_last are sampled only on acc_fire.
  - i_valid may drop without a transfer; the accumulator holds.
- Arithmetic: unsigned, i_data zero-extended to OW; no saturation needed by construction.
- Counters: cnt width CW, never exceeds N-1 at rest; occupancy 0..2, never wraps.

Test Plan:
- N=4, feed 1,2,3,4 back-to-back, o_ready=1 -> one record sum=10 count=4 last=0, o_valid 1 cycle after the 4th accept.
- Feed 255×4 -> sum=1020 (OW=10) count=4; then 7 with i_last=1 -> sum=7 count=1 last=1.
- o_ready=0, feed 12 samples of value 1 -> two records of sum=4 queue. i_ready goes 0 the cycle after occupancy reaches 2; the 9th sample is not accepted. Raise o_ready -> records drain in order, i_ready returns 1 the cycle after the first pop, and the third block completes sum=4.
- Feed 5,6 with i_last on 6 while the FIFO holds 1 entry and o_ready=1 that cycle -> simultaneous push and pop, occupancy stays 1, next head sum=11 count=2 last=1.
- Feed 9,9 (cnt=2), assert rst for 1 cycle, then feed 1,1,1,1 -> single record sum=4 count=4; no record containing 9.
- i_last on the 4th sample of 1,1,1,1 -> sum=4 count=4 last=0. i_valid gaps of random length between samples -> identical results.

Source files
------------

// File: rtl/stream_block_sum_if.sv
// Handshake bundle between a sample producer, stream_block_sum and the consumer
// of its block records. The "i_" group is the sample stream into the block and
// the "o_" group is the record stream out of it.
interface stream_block_sum_if #(
  parameter int DW = 8,
  parameter int N  = 4
);
  localparam int CW = $clog2(N + 1);
  localparam int OW = DW + $clog2(N);

  logic          i_valid;
  logic          i_ready;
  logic [DW-1:0] i_data;
  logic          i_last;
  logic          o_valid;
  logic          o_ready;
  logic [OW-1:0] o_sum;
  logic [CW-1:0] o_count;
  logic          o_last;

  // Producer of samples and consumer of records.
  modport master (
    output i_valid, i_data, i_last, o_ready,
    input  i_ready, o_valid, o_sum, o_count, o_last
  );

  // The block-sum engine itself.
  modport slave (
    input  i_valid, i_data, i_last, o_ready,
    output i_ready, o_valid, o_sum, o_count, o_last
  );
endinterface

// File: rtl/stream_block_sum.sv
// Sums each block of N unsigned samples (or a shorter block ended by i_last)
// and queues one {sum, count, last} record per block in a 2-entry FIFO.
// i_ready comes only from registers, so it has no path from o_ready/i_valid.
module stream_block_sum #(
  parameter int DW = 8,
  parameter int N  = 4
) (
  input logic           clk,
  input logic           rst,
  stream_block_sum_if.slave bus
);
  localparam int CW = $clog2(N + 1);
  localparam int OW = DW + $clog2(N);

  logic          rst_q;
  logic [OW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    occ_q, occ_d;
  logic          wr_ptr_q, rd_ptr_q;

  logic [OW-1:0] fifo_sum_q  [2];
  logic [CW-1:0] fifo_cnt_q  [2];
  logic          fifo_last_q [2];

  logic          acc_fire;
  logic          close_blk;
  logic          full_blk;
  logic          pop;
  logic [CW-1:0] cnt_inc;
  logic [OW-1:0] sum_nxt;

  // Uniform gating: a full FIFO stalls every sample, not just closing ones.
  assign bus.i_ready = !rst_q && (occ_q != 2'd2);
  assign bus.o_valid = (occ_q != 2'd0);
  assign bus.o_sum   = bus.o_valid ? fifo_sum_q[rd_ptr_q]  : '0;
  assign bus.o_count = bus.o_valid ? fifo_cnt_q[rd_ptr_q]  : '0;
  assign bus.o_last  = bus.o_valid ? fifo_last_q[rd_ptr_q] : 1'b0;

  // Accumulator/counter next state and FIFO occupancy bookkeeping.
  always_comb begin
    acc_fire  = bus.i_valid & bus.i_ready;
    cnt_inc   = cnt_q + CW'(1);
    full_blk  = (cnt_inc == CW'(N));
    close_blk = acc_fire & (full_blk | bus.i_last);
    sum_nxt   = acc_q + OW'(bus.i_data);
    pop       = bus.o_valid & bus.o_ready;

    acc_d = acc_q;
    cnt_d = cnt_q;
    if (acc_fire) begin
      if (close_blk) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum_nxt;
        cnt_d = cnt_inc;
      end
    end

    case ({close_blk, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  // Control state; reset discards any partial block and queued records.
  always_ff @(posedge clk) begin
    if (rst) begin
      rst_q    <= 1'b1;
      acc_q    <= '0;
      cnt_q    <= '0;
      occ_q    <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      rst_q <= 1'b0;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      occ_q <= occ_d;
      if (close_blk) wr_ptr_q <= ~wr_ptr_q;
      if (pop)       rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // FIFO storage; contents are masked by o_valid so no reset is needed.
  // last is only set for a short block; i_last on the N-th sample is a full block.
  always_ff @(posedge clk) begin
    if (close_blk && !rst) begin
      fifo_sum_q[wr_ptr_q]  <= sum_nxt;
      fifo_cnt_q[wr_ptr_q]  <= cnt_inc;
      fifo_last_q[wr_ptr_q] <= bus.i_last & ~full_blk;
    end
  end

endmodule

// File: tb/tb_stream_block_sum.sv
// Bench for stream_block_sum: a reference model turns every accepted sample
// into expected block records on a queue; records leaving the DUT are popped
// and compared. Directed checks cover reset, latency and back-pressure.
module tb_stream_block_sum;
  localparam int DW = 8;
  localparam int N  = 4;

  typedef struct {
    int sum;
    int cnt;
    bit last;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  stream_block_sum_if #(.DW(DW), .N(N)) bus ();

  stream_block_sum #(.DW(DW), .N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  rec_t exp_q[$];
  int   m_acc = 0;
  int   m_cnt = 0;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Model and scoreboard, sampled mid-cycle while inputs are stable.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_acc = 0;
      m_cnt = 0;
    end else begin
      if (bus.o_valid && bus.o_ready) begin
        check("sb_nonempty", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          rec_t r;
          r = exp_q.pop_front();
          check("rec_sum",   int'(bus.o_sum),   r.sum);
          check("rec_count", int'(bus.o_count), r.cnt);
          check("rec_last",  int'(bus.o_last),  int'(r.last));
        end
      end
      if (bus.i_valid && bus.i_ready) begin
        m_acc += int'(bus.i_data);
        m_cnt++;
        if (m_cnt == N || bus.i_last) begin
          rec_t r;
          r.sum  = m_acc;
          r.cnt  = m_cnt;
          r.last = bus.i_last && (m_cnt != N);
          exp_q.push_back(r);
          m_acc = 0;
          m_cnt = 0;
        end
      end
    end
  end

  // Offers one sample and returns #1 after the edge that accepted it.
  task automatic send(input int d, input bit l);
    int t;
    t = 0;
    bus.i_valid = 1'b1;
    bus.i_data  = d[DW-1:0];
    bus.i_last  = l;
    @(negedge clk);
    while (!bus.i_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bus.i_ready) check("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    bus.i_last  = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int len;
    int t;
    bit l;
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    bus.i_last  = 1'b0;
    bus.o_ready = 1'b1;

    // Reset values
    tick();
    tick();
    check("rst_o_valid", int'(bus.o_valid), 0);
    check("rst_o_sum",   int'(bus.o_sum),   0);
    check("rst_o_count", int'(bus.o_count), 0);
    check("rst_o_last",  int'(bus.o_last),  0);
    check("rst_i_ready", int'(bus.i_ready), 0);
    rst = 1'b0;
    tick();
    check("post_rst_i_ready", int'(bus.i_ready), 1);

    // 1,2,3,4 back-to-back: record visible one cycle after 4th accept
    send(1, 0);
    send(2, 0);
    send(3, 0);
    check("no_early_valid", int'(bus.o_valid), 0);
    send(4, 0);
    check("lat_o_valid", int'(bus.o_valid), 1);
    check("lat_o_sum",   int'(bus.o_sum),   10);
    tick();

    // Max-value block, then a one-sample short block
    repeat (4) send(255, 0);
    check("max_sum", int'(bus.o_sum), 1020);
    send(7, 1);
    check("short_sum",  int'(bus.o_sum),  7);
    check("short_last", int'(bus.o_last), 1);
    tick();

    // Back-pressure: two blocks fill the FIFO, 9th sample refused
    bus.o_ready = 1'b0;
    repeat (8) send(1, 0);
    check("full_i_ready", int'(bus.i_ready), 0);
    bus.i_valid = 1'b1;
    bus.i_data  = 8'd1;
    repeat (3) begin
      @(negedge clk);
      check("stall_i_ready", int'(bus.i_ready), 0);
      check("stall_o_sum",   int'(bus.o_sum),   4);
      check("stall_o_count", int'(bus.o_count), 4);
    end
    tick();
    bus.i_valid = 1'b0;
    bus.o_ready = 1'b1;
    tick();
    check("pop_i_ready", int'(bus.i_ready), 1);
    repeat (4) send(1, 0);
    tick();

    // Simultaneous push and pop with one record queued
    bus.o_ready = 1'b0;
    repeat (4) send(2, 0);
    send(5, 0);
    bus.i_valid = 1'b1;
    bus.i_data  = 8'd6;
    bus.i_last  = 1'b1;
    bus.o_ready = 1'b1;
    @(negedge clk);
    check("pp_i_ready", int'(bus.i_ready), 1);
    tick();
    bus.o_ready = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_last  = 1'b0;
    check("pp_o_valid", int'(bus.o_valid), 1);
    check("pp_i_ready_after", int'(bus.i_ready), 1);
    check("pp_o_sum",   int'(bus.o_sum),   11);
    check("pp_o_count", int'(bus.o_count), 2);
    check("pp_o_last",  int'(bus.o_last),  1);
    bus.o_ready = 1'b1;
    tick();
    tick();

    // Reset with a queued record and a partial block discards both
    bus.o_ready = 1'b0;
    repeat (4) send(3, 0);
    send(9, 0);
    send(9, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_o_valid", int'(bus.o_valid), 0);
    bus.o_ready = 1'b1;
    repeat (4) send(1, 0);
    check("after_rst_sum",   int'(bus.o_sum),   4);
    check("after_rst_count", int'(bus.o_count), 4);
    tick();

    // i_last on the N-th sample is a normal full block
    repeat (3) send(1, 0);
    send(1, 1);
    check("last_on_n_last", int'(bus.o_last), 0);
    tick();

    // Random values, block lengths and idle gaps
    for (int b = 0; b < 12; b++) begin
      len = $urandom_range(1, N);
      for (int i = 0; i < len; i++) begin
        l = (i == len - 1) && ((len < N) || ($urandom_range(0, 1) == 1));
        send($urandom_range(0, 255), l);
        repeat ($urandom_range(0, 3)) tick();
      end
    end

    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      tick();
      t++;
    end
    check("sb_drained", exp_q.size(), 0);
    check("end_o_valid", int'(bus.o_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
